mac_sdram_ctrl: RTL

- Single-port SDRAM controller that consumes the memory-side request bus from the Mac core: ram_addr, sdram_din, sdram_ds, sdram_we, sdram_oe and busPhase. It returns sdram_do.
- Each 8-phase bus cycle (busPhase 0..7) carries exactly one SDRAM transaction slot: a read, a write or an auto-refresh.
- It sits between the Mac core and the external 16-bit SDR SDRAM, and also performs power-up initialisation.

---
 rtl/mac_sdram_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mac_sdram_ctrl.sv
// SDRAM controller for the Mac core memory bus: one read/write/refresh slot per
// 8-phase bus cycle, plus power-up initialisation of a 16-bit SDR SDRAM.
`timescale 1ns/1ps
module mac_sdram_ctrl #(
  parameter logic [15:0] INIT_WAIT      = 16'd10000,
  parameter int unsigned RASCAS_DELAY   = 2,
  parameter int unsigned CAS_LATENCY    = 2,
  parameter logic [7:0]  REFRESH_CYCLES = 8'd48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  busPhase,
  input  logic [20:0] addr,
  input  logic [15:0] din,
  input  logic [1:0]  ds,
  input  logic        we,
  input  logic        oe,
  output logic [15:0] dout,
  output logic        init_done,
  output logic        sd_cke,
  output logic        sd_cs_n,
  output logic        sd_ras_n,
  output logic        sd_cas_n,
  output logic        sd_we_n,
  output logic [1:0]  sd_ba,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_dqm,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe,
  input  logic [15:0] sd_dq_in
);

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  localparam logic [2:0]  PH_CMD    = 3'(RASCAS_DELAY);
  localparam logic [2:0]  PH_CAP    = 3'(RASCAS_DELAY + CAS_LATENCY + 1);
  // Single-location writes, sequential, burst length 1
  localparam logic [12:0] MODE_WORD = {3'b000, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MODE, S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] a_q, a_d;
  logic [1:0]  dqm_q, dqm_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dout_q, dout_d;
  logic        init_done_q, init_done_d;
  logic [15:0] icnt_q, icnt_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [8:0]  col_q, col_d;

  logic phase0_c;
  logic req_c;

  assign phase0_c = (busPhase == 3'd0);
  assign req_c    = init_done_q && (oe || we);

  // Next-state and command generation
  always_comb begin
    state_d     = state_q;
    cmd_d       = CMD_NOP;
    ba_d        = ba_q;
    a_d         = a_q;
    dqm_d       = 2'b11;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    dout_d      = dout_q;
    init_done_d = init_done_q;
    icnt_d      = icnt_q;
    rcnt_d      = rcnt_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    col_d       = col_q;

    unique case (state_q)
      S_INIT_WAIT: begin
        if (icnt_q != 16'd0) begin
          icnt_d = icnt_q - 16'd1;
        end else if (phase0_c) begin
          cmd_d   = CMD_PRECHARGE;
          a_d     = 13'h0400;
          state_d = S_INIT_PRE;
        end
      end
      S_INIT_PRE: begin
        if (phase0_c) begin
          cmd_d   = CMD_REFRESH;
          state_d = S_INIT_REF1;
        end
      end
      S_INIT_REF1: begin
        if (phase0_c) begin
          cmd_d   = CMD_REFRESH;
          state_d = S_INIT_REF2;
        end
      end
      S_INIT_REF2: begin
        if (phase0_c) begin
          cmd_d   = CMD_LOAD_MODE;
          ba_d    = 2'b00;
          a_d     = MODE_WORD;
          state_d = S_INIT_MODE;
        end
      end
      S_INIT_MODE: begin
        if (phase0_c) begin
          init_done_d = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        // Slot start: open the row, or refresh when the slot is idle and due
        if (phase0_c) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (req_c) begin
            cmd_d = CMD_ACTIVE;
            ba_d  = {1'b0, addr[20]};
            a_d   = {2'b00, addr[19:9]};
            col_d = addr[8:0];
            wr_d  = we;
            rd_d  = ~we;
          end else if (rcnt_q == 8'd0) begin
            cmd_d = CMD_REFRESH;
          end
          if (!req_c && rcnt_q == 8'd0) begin
            rcnt_d = REFRESH_CYCLES;
          end else if (rcnt_q != 8'd0) begin
            rcnt_d = rcnt_q - 8'd1;
          end
        end
        // Column access with auto-precharge closes the row within the slot
        if (busPhase == PH_CMD && (rd_q || wr_q)) begin
          a_d = {2'b00, 1'b1, 1'b0, col_q};
          if (wr_q) begin
            cmd_d    = CMD_WRITE;
            dq_out_d = din;
            dq_oe_d  = 1'b1;
            dqm_d    = ~ds;
          end else begin
            cmd_d = CMD_READ;
            dqm_d = 2'b00;
          end
        end
        if (busPhase == PH_CAP && rd_q) begin
          dout_d = sd_dq_in;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT_WAIT;
      cmd_q       <= CMD_NOP;
      ba_q        <= 2'b00;
      a_q         <= 13'h0000;
      dqm_q       <= 2'b11;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      dout_q      <= 16'h0000;
      init_done_q <= 1'b0;
      icnt_q      <= INIT_WAIT;
      rcnt_q      <= REFRESH_CYCLES;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      col_q       <= 9'h000;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      a_q         <= a_d;
      dqm_q       <= dqm_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      dout_q      <= dout_d;
      init_done_q <= init_done_d;
      icnt_q      <= icnt_d;
      rcnt_q      <= rcnt_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      col_q       <= col_d;
    end
  end

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
  assign sd_cke    = 1'b1;
  assign sd_ba     = ba_q;
  assign sd_a      = a_q;
  assign sd_dqm    = dqm_q;
  assign sd_dq_out = dq_out_q;
  assign sd_dq_oe  = dq_oe_q;
  assign dout      = dout_q;
  assign init_done = init_done_q;

endmodule
